// File: rtl/dll_rx_acknak_if.sv
// Receive-side link bundle: inbound frame words, released payload and ACK/NAK report.
interface dll_rx_acknak_if;
    logic [15:0] din;
    logic        din_valid;
    logic        sof;
    logic        din_ready;
    logic [15:0] dout;
    logic        dout_valid;
    logic        dout_ready;
    logic [1:0]  ack_nack;
    logic [11:0] ack_seq;

    modport master (
        output din, din_valid, sof, dout_ready,
        input  din_ready, dout, dout_valid, ack_nack, ack_seq
    );

    modport slave (
        input  din, din_valid, sof, dout_ready,
        output din_ready, dout, dout_valid, ack_nack, ack_seq
    );
endinterface

// File: rtl/dll_rx_acknak.sv
// Data-link receive checker: LCRC-32 and sequence check per frame, in-order payload
// release upstream, one-cycle ACK/NAK pulse with reported sequence number.
module dll_rx_acknak #(
    parameter int unsigned PAYLOAD_WORDS = 7,
    parameter bit          NAK_SUPPRESS  = 1'b1
) (
    input logic             clk,
    input logic             reset_n,
    dll_rx_acknak_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_RECV, S_CHECK, S_DRAIN} state_t;

    localparam logic [31:0] POLY = 32'h04C1_1DB7;
    localparam int unsigned CW   = $clog2(PAYLOAD_WORDS + 3);
    localparam int unsigned IW   = (PAYLOAD_WORDS > 1) ? $clog2(PAYLOAD_WORDS) : 1;
    localparam logic [CW-1:0] PAY_CNT    = CW'(PAYLOAD_WORDS);
    localparam logic [CW-1:0] CRC_HI_CNT = CW'(PAYLOAD_WORDS + 1);
    localparam logic [CW-1:0] LAST_CNT   = CW'(PAYLOAD_WORDS + 2);
    localparam logic [IW-1:0] LAST_IDX   = IW'(PAYLOAD_WORDS - 1);

    state_t       r_state, w_next;
    logic [CW-1:0] r_cnt;
    logic [IW-1:0] r_rd_idx, w_wr_idx;
    logic [15:0]  r_buf [PAYLOAD_WORDS];
    logic [31:0]  r_crc, r_rx_crc;
    logic [11:0]  r_seq, r_next_seq, r_ack_seq, w_diff;
    logic         r_nak_sched;
    logic [15:0]  r_dout;
    logic         r_dout_valid;
    logic [1:0]   r_ack_nack;
    logic         w_din_ready, w_take, w_xfer;
    logic         w_crc_ok, w_in_order, w_dup, w_nak_allowed;

    function automatic logic [31:0] crc16_step(input logic [31:0] c, input logic [15:0] d);
        logic [31:0] v;
        v = c;
        for (int unsigned i = 0; i < 16; i++) begin
            v = {v[30:0], 1'b0} ^ ((v[31] ^ d[4'(15 - i)]) ? POLY : '0);
        end
        return v;
    endfunction

    // r_cnt holds the index of the next expected word within the frame
    assign w_wr_idx      = IW'(r_cnt - CW'(1));
    assign w_diff        = r_next_seq - r_seq;
    assign w_crc_ok      = (r_crc == r_rx_crc);
    assign w_in_order    = (r_seq == r_next_seq);
    assign w_dup         = (w_diff != '0) && (w_diff <= 12'd2048);
    assign w_nak_allowed = !(NAK_SUPPRESS && r_nak_sched);

    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_take && bus.sof) w_next = S_RECV;
            S_RECV:  if (w_take && !bus.sof && r_cnt == LAST_CNT) w_next = S_CHECK;
            S_CHECK: w_next = (w_crc_ok && w_in_order) ? S_DRAIN : S_IDLE;
            S_DRAIN: if (w_xfer && r_rd_idx == LAST_IDX) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_din_ready = reset_n && (r_state == S_IDLE || r_state == S_RECV);
        w_take      = bus.din_valid && w_din_ready;
        w_xfer      = (r_state == S_DRAIN) && r_dout_valid && bus.dout_ready;
    end

    always_ff @(posedge clk) begin
        if (r_state == S_RECV && w_take && !bus.sof && r_cnt <= PAY_CNT)
            r_buf[w_wr_idx] <= bus.din;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt        <= '0;
            r_rd_idx     <= '0;
            r_crc        <= '1;
            r_rx_crc     <= '0;
            r_seq        <= '0;
            r_next_seq   <= '0;
            r_ack_seq    <= '0;
            r_nak_sched  <= 1'b0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_ack_nack   <= 2'b00;
        end else begin
            r_ack_nack <= 2'b00;
            unique case (r_state)
                S_IDLE, S_RECV: begin
                    if (w_take && bus.sof) begin
                        r_seq <= bus.din[11:0];
                        r_crc <= crc16_step('1, bus.din);
                        r_cnt <= CW'(1);
                    end else if (w_take && r_state == S_RECV) begin
                        r_cnt <= r_cnt + CW'(1);
                        if (r_cnt <= PAY_CNT)
                            r_crc <= crc16_step(r_crc, bus.din);
                        else if (r_cnt == CRC_HI_CNT)
                            r_rx_crc[31:16] <= bus.din;
                        else
                            r_rx_crc[15:0] <= bus.din;
                    end
                end
                S_CHECK: begin
                    if (w_crc_ok && w_in_order) begin
                        r_ack_nack   <= 2'b01;
                        r_ack_seq    <= r_seq;
                        r_next_seq   <= r_next_seq + 12'd1;
                        r_nak_sched  <= 1'b0;
                        r_dout       <= r_buf[0];
                        r_dout_valid <= 1'b1;
                        r_rd_idx     <= '0;
                    end else if (w_crc_ok && w_dup) begin
                        r_ack_nack <= 2'b01;
                        r_ack_seq  <= r_next_seq - 12'd1;
                    end else begin
                        if (w_nak_allowed) begin
                            r_ack_nack <= 2'b10;
                            r_ack_seq  <= r_next_seq - 12'd1;
                        end
                        r_nak_sched <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (w_xfer) begin
                        if (r_rd_idx == LAST_IDX) begin
                            r_dout_valid <= 1'b0;
                        end else begin
                            r_dout   <= r_buf[r_rd_idx + 1'b1];
                            r_rd_idx <= r_rd_idx + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.din_ready  = w_din_ready;
    assign bus.dout       = r_dout;
    assign bus.dout_valid = r_dout_valid;
    assign bus.ack_nack   = r_ack_nack;
    assign bus.ack_seq    = r_ack_seq;
endmodule

// File: tb/tb_dll_rx_acknak.sv
// Directed bench for dll_rx_acknak: frame vector table plus abort, reset and seq-wrap sequences.
module tb_dll_rx_acknak;
    localparam int P = 7;
    localparam logic [1:0] AN_NONE = 2'b00;
    localparam logic [1:0] AN_ACK  = 2'b01;
    localparam logic [1:0] AN_NAK  = 2'b10;

    typedef struct {
        logic [11:0] seq;
        bit          flip;
        bit          gap;
        bit          toggle;
        logic [1:0]  an;
        logic [11:0] aseq;
        bit          drain;
    } vec_t;

    logic clk;
    logic reset_n;
    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t vecs [17];

    dll_rx_acknak_if bus ();
    dll_rx_acknak_if bus2 ();

    dll_rx_acknak #(.PAYLOAD_WORDS(P), .NAK_SUPPRESS(1'b1)) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    dll_rx_acknak #(.PAYLOAD_WORDS(1), .NAK_SUPPRESS(1'b1)) u_wrap (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [15:0] d);
        logic [31:0] r;
        r = c;
        for (int b = 15; b >= 0; b--) begin
            if (r[31] ^ d[4'(b)]) r = (r << 1) ^ 32'h04C11DB7;
            else                  r = r << 1;
        end
        return r;
    endfunction

    function automatic logic [15:0] pay(input logic [11:0] s, input int k);
        return {s[7:0] ^ 8'h5A, 8'(k * 37 + 1)};
    endfunction

    task automatic send_frame(input logic [11:0] s, input bit flip, input bit gap, input int nw);
        logic [15:0] w [P+3];
        logic [31:0] c;
        w[0] = {4'b0, s};
        for (int k = 1; k <= P; k++) w[k] = pay(s, k);
        c = 32'hFFFF_FFFF;
        for (int k = 0; k <= P; k++) c = crc_upd(c, w[k]);
        w[P+1] = c[31:16];
        w[P+2] = c[15:0];
        if (flip) w[3][5] = ~w[3][5];
        for (int i = 0; i < nw; i++) begin
            if (gap && i == 3) begin
                bus.din_valid = 1'b0;
                bus.sof       = 1'b1;
                bus.din       = 16'hDEAD;
                repeat (2) begin @(posedge clk); #1; end
            end
            chk("din_ready_rx", bus.din_ready, 1);
            bus.din       = w[i];
            bus.din_valid = 1'b1;
            bus.sof       = (i == 0);
            @(posedge clk); #1;
            chk("ack_nack_rx", bus.ack_nack, AN_NONE);
        end
        bus.din_valid = 1'b0;
        bus.sof       = 1'b0;
    endtask

    task automatic drain_check(input logic [11:0] s, input bit toggle);
        int k = 0;
        int cyc = 0;
        bit rdy;
        while (k < P && cyc < 64) begin
            rdy = toggle ? ((cyc % 3) != 1) : 1'b1;
            bus.dout_ready = rdy;
            chk("dout_valid_drain", bus.dout_valid, 1);
            chk("dout_word", bus.dout, pay(s, k + 1));
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) chk("ack_nack_pulse_end", bus.ack_nack, AN_NONE);
            if (rdy) k++;
        end
        bus.dout_ready = 1'b1;
        if (k < P) chk("drain_timeout", k, P);
        if (!toggle) chk("drain_cycles", cyc, P);
        chk("dout_valid_after", bus.dout_valid, 0);
        chk("din_ready_after", bus.din_ready, 1);
    endtask

    task automatic run_frame(input vec_t v);
        send_frame(v.seq, v.flip, v.gap, P + 3);
        chk("din_ready_check", bus.din_ready, 0);
        chk("ack_nack_check", bus.ack_nack, AN_NONE);
        // junk offered during CHECK must be ignored
        bus.din_valid = 1'b1;
        bus.sof       = 1'b1;
        bus.din       = 16'h0ABC;
        @(posedge clk); #1;
        bus.din_valid = 1'b0;
        bus.sof       = 1'b0;
        chk("ack_nack", bus.ack_nack, v.an);
        chk("ack_seq", bus.ack_seq, v.aseq);
        chk("dout_valid_n1", bus.dout_valid, v.drain);
        if (v.drain) begin
            drain_check(v.seq, v.toggle);
        end else begin
            @(posedge clk); #1;
            chk("ack_nack_clear", bus.ack_nack, AN_NONE);
            chk("dout_valid_none", bus.dout_valid, 0);
            chk("din_ready_idle", bus.din_ready, 1);
        end
    endtask

    task automatic wrap_frame(input logic [11:0] s, input logic [11:0] exp_seq, input bit do_chk);
        logic [15:0] w [4];
        logic [31:0] c;
        w[0] = {4'b0, s};
        w[1] = pay(s, 1);
        c    = crc_upd(crc_upd(32'hFFFF_FFFF, w[0]), w[1]);
        w[2] = c[31:16];
        w[3] = c[15:0];
        for (int i = 0; i < 4; i++) begin
            bus2.din       = w[i];
            bus2.din_valid = 1'b1;
            bus2.sof       = (i == 0);
            @(posedge clk); #1;
        end
        bus2.din_valid = 1'b0;
        bus2.sof       = 1'b0;
        @(posedge clk); #1;
        if (do_chk) begin
            chk("wrap_ack_nack", bus2.ack_nack, AN_ACK);
            chk("wrap_ack_seq", bus2.ack_seq, exp_seq);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        vecs = '{
            '{12'd0,    1'b0, 1'b0, 1'b0, AN_ACK,  12'd0, 1'b1},
            '{12'd1,    1'b0, 1'b1, 1'b0, AN_ACK,  12'd1, 1'b1},
            '{12'd2,    1'b0, 1'b0, 1'b1, AN_ACK,  12'd2, 1'b1},
            '{12'd3,    1'b0, 1'b0, 1'b0, AN_ACK,  12'd3, 1'b1},
            '{12'd4,    1'b0, 1'b0, 1'b0, AN_ACK,  12'd4, 1'b1},
            '{12'd7,    1'b0, 1'b0, 1'b0, AN_NAK,  12'd4, 1'b0},
            '{12'd5,    1'b1, 1'b0, 1'b0, AN_NONE, 12'd4, 1'b0},
            '{12'd9,    1'b0, 1'b0, 1'b0, AN_NONE, 12'd4, 1'b0},
            '{12'd5,    1'b0, 1'b0, 1'b0, AN_ACK,  12'd5, 1'b1},
            '{12'd5,    1'b0, 1'b0, 1'b0, AN_ACK,  12'd5, 1'b0},
            '{12'd6,    1'b1, 1'b0, 1'b0, AN_NAK,  12'd5, 1'b0},
            '{12'd6,    1'b0, 1'b0, 1'b1, AN_ACK,  12'd6, 1'b1},
            '{12'd2055, 1'b0, 1'b0, 1'b0, AN_ACK,  12'd6, 1'b0},
            '{12'd2054, 1'b0, 1'b0, 1'b0, AN_NAK,  12'd6, 1'b0},
            '{12'd6,    1'b0, 1'b0, 1'b0, AN_ACK,  12'd6, 1'b0},
            '{12'd8,    1'b0, 1'b0, 1'b0, AN_NONE, 12'd6, 1'b0},
            '{12'd7,    1'b0, 1'b1, 1'b1, AN_ACK,  12'd7, 1'b1}
        };

        reset_n         = 1'b0;
        bus.din         = '0;
        bus.din_valid   = 1'b0;
        bus.sof         = 1'b0;
        bus.dout_ready  = 1'b1;
        bus2.din        = '0;
        bus2.din_valid  = 1'b0;
        bus2.sof        = 1'b0;
        bus2.dout_ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        chk("rst_din_ready", bus.din_ready, 0);
        chk("rst_dout", bus.dout, 0);
        chk("rst_dout_valid", bus.dout_valid, 0);
        chk("rst_ack_nack", bus.ack_nack, AN_NONE);
        chk("rst_ack_seq", bus.ack_seq, 0);
        reset_n = 1'b1;
        #1;
        chk("rst_release_din_ready", bus.din_ready, 1);

        for (int i = 0; i < 17; i++) run_frame(vecs[i]);

        // Aborted partial frame, then good frame seq 0 with backpressure
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        #1;
        send_frame(12'd0, 1'b0, 1'b0, 4);
        run_frame('{12'd0, 1'b0, 1'b0, 1'b1, AN_ACK, 12'd0, 1'b1});

        // Reset asserted in the middle of DRAIN
        send_frame(12'd1, 1'b0, 1'b0, P + 3);
        @(posedge clk); #1;
        chk("middrain_ack", bus.ack_nack, AN_ACK);
        chk("middrain_dout_valid", bus.dout_valid, 1);
        repeat (2) begin @(posedge clk); #1; end
        chk("middrain_dout", bus.dout, pay(12'd1, 3));
        reset_n = 1'b0;
        @(posedge clk); #1;
        chk("middrain_rst_dout_valid", bus.dout_valid, 0);
        chk("middrain_rst_dout", bus.dout, 0);
        chk("middrain_rst_ack_nack", bus.ack_nack, AN_NONE);
        chk("middrain_rst_ack_seq", bus.ack_seq, 0);
        chk("middrain_rst_din_ready", bus.din_ready, 0);
        reset_n = 1'b1;
        #1;
        chk("middrain_release_din_ready", bus.din_ready, 1);
        run_frame('{12'd0, 1'b0, 1'b0, 1'b0, AN_ACK, 12'd0, 1'b1});

        // Sequence wrap on a short-payload instance: 0..4095, then 0 again
        for (int s = 0; s < 4096; s++)
            wrap_frame(12'(s), 12'(s), (s < 2) || (s >= 4094) || (s % 1024 == 0));
        wrap_frame(12'd0, 12'd0, 1'b1);
        wrap_frame(12'd0, 12'd0, 1'b1);
        chk("wrap_dup_dout_valid", bus2.dout_valid, 0);
        wrap_frame(12'd1, 12'd1, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
